// File: rtl/run_pattern_gen.sv
// Serializes WIDTH-bit frames LSB first and predicts a run detector's Moore
// output (z_exp) together with a saturating per-frame count of z_exp-high cycles.
module run_pattern_gen #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data,
   input  logic             valid,
   output logic             ready,
   output logic             w,
   output logic             w_valid,
   output logic             z_exp,
   output logic [7:0]       hits,
   output logic             done,
   output logic [2:0]       state
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      SHIFT = 3'b010,
      DONE  = 3'b100
   } state_t;

   state_t           cur, nxt;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             prev, have_prev;
   logic             last_bit, match;

   assign state    = cur;
   assign last_bit = (cnt == CW'(WIDTH - 1));
   // A run continues when the bit on w now equals the one sent last cycle.
   assign match    = have_prev & (sr[0] == prev);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur <= IDLE;
      else       cur <= nxt;
   end

   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      nxt     = cur;
      ready   = 1'b0;
      w       = 1'b0;
      w_valid = 1'b0;
      done    = 1'b0;
      case (cur)
         IDLE: begin
            ready = 1'b1;
            if (valid) nxt = SHIFT;
         end
         SHIFT: begin
            w       = sr[0];
            w_valid = 1'b1;
            if (last_bit) nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr        <= '0;
         cnt       <= '0;
         prev      <= 1'b0;
         have_prev <= 1'b0;
         z_exp     <= 1'b0;
         hits      <= 8'd0;
      end else begin
         case (cur)
            IDLE: begin
               z_exp <= 1'b0;
               if (valid) begin
                  sr        <= data;
                  cnt       <= '0;
                  prev      <= 1'b0;
                  have_prev <= 1'b0;
                  hits      <= 8'd0;
               end
            end
            SHIFT: begin
               sr        <= sr >> 1;
               cnt       <= cnt + CW'(1);
               prev      <= sr[0];
               have_prev <= 1'b1;
               z_exp     <= match;
               if (match && hits != 8'hFF) hits <= hits + 8'd1;
            end
            default: z_exp <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_run_pattern_gen.sv
// Directed bench for run_pattern_gen (WIDTH=8): a frame model fills a scoreboard
// on accept; a negedge monitor pops and compares every SHIFT and DONE cycle.
module tb_run_pattern_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data;
   logic       valid;
   logic       ready, w, w_valid, z_exp, done;
   logic [7:0] hits;
   logic [2:0] state;

   typedef struct packed {
      logic       w;
      logic       z;
      logic       is_done;
      logic [7:0] hits;
   } exp_t;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;
   bit   mon_en     = 1'b0;

   run_pattern_gen #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .data    (data),
      .valid   (valid),
      .ready   (ready),
      .w       (w),
      .w_valid (w_valid),
      .z_exp   (z_exp),
      .hits    (hits),
      .done    (done),
      .state   (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected stream for one frame: z during bit j reflects whether bits j-1
   // and j-2 matched; the first bit of a frame never follows a valid history.
   task automatic push_frame(input logic [7:0] d);
      logic [7:0] eq;
      int         h;
      exp_t       e;
      h = 0;
      for (int j = 0; j < 8; j++) eq[j] = (j >= 1) && (d[j] == d[j-1]);
      for (int j = 0; j < 8; j++) begin
         e.w       = d[j];
         e.z       = (j >= 1) ? eq[j-1] : 1'b0;
         e.is_done = 1'b0;
         e.hits    = 8'(h);
         q.push_back(e);
         h += int'(eq[j]);
      end
      e.w       = 1'b0;
      e.z       = eq[7];
      e.is_done = 1'b1;
      e.hits    = 8'(h);
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         check("onehot", 32'($onehot(state)), 32'd1);
         check("ready_vs_idle", ready, state == 3'b001);
         if (!w_valid) check("w_quiet", w, 1'b0);
         if (w_valid || done) begin
            if (q.size() == 0) begin
               check("unexpected_out", {w_valid, done}, 2'b00);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("w", w, e.w);
               check("z_exp", z_exp, e.z);
               check("hits", hits, e.hits);
               check("done", done, e.is_done);
            end
         end
      end
   end

   // Presents a frame in the next IDLE cycle; returns at the first SHIFT negedge.
   task automatic send(input logic [7:0] d, input bit hold_valid);
      int n;
      n = 0;
      @(negedge clk);
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", ready, 1'b1);
      data  = d;
      valid = 1'b1;
      push_frame(d);
      @(negedge clk);
      if (!hold_valid) valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      valid = 1'b0;
      data  = 8'h00;
      #2 reset = 1'b1;
      #1;
      check("rst_state", state, 3'b001);
      check("rst_ready", ready, 1'b1);
      check("rst_w", w, 1'b0);
      check("rst_w_valid", w_valid, 1'b0);
      check("rst_z", z_exp, 1'b0);
      check("rst_hits", hits, 8'd0);
      check("rst_done", done, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;

      // All zeros: z high from SHIFT cycle 3 through DONE, hits held afterwards.
      send(8'h00, 1'b0);
      wait_done();
      check("hits_hold_idle", hits, 8'd7);
      check("z_idle", z_exp, 1'b0);

      // Alternating bits: done exactly 9 cycles after accept.
      send(8'hAA, 1'b0);
      repeat (7) @(negedge clk);
      check("aa_done_early", done, 1'b0);
      @(negedge clk);
      check("aa_done_at_9", done, 1'b1);
      @(negedge clk);
      check("aa_hits_idle", hits, 8'd0);

      send(8'h0F, 1'b0);
      wait_done();

      // Back-to-back with valid held: second frame taken in first IDLE cycle.
      send(8'h80, 1'b1);
      data = 8'h01;
      push_frame(8'h01);
      repeat (8) @(negedge clk);
      check("b2b_done", state, 3'b100);
      @(negedge clk);
      check("b2b_idle", state, 3'b001);
      @(negedge clk);
      check("b2b_accepted", state, 3'b010);
      valid = 1'b0;
      wait_done();
      check("b2b_hits_idle", hits, 8'd6);

      // Input noise while busy must not disturb the frame.
      send(8'h3C, 1'b0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("busy_ready", ready, 1'b0);
         valid = ~valid;
         data  = 8'($urandom);
      end
      valid = 1'b0;
      wait_done();

      // Reset mid-SHIFT aborts at once with no done pulse.
      send(8'hAA, 1'b0);
      @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      mon_en = 1'b0;
      #1;
      check("mid_rst_state", state, 3'b001);
      check("mid_rst_w_valid", w_valid, 1'b0);
      check("mid_rst_w", w, 1'b0);
      check("mid_rst_z", z_exp, 1'b0);
      check("mid_rst_hits", hits, 8'd0);
      check("mid_rst_done", done, 1'b0);
      q.delete();
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("no_done_after_abort", done, 1'b0);
      end

      send(8'hC5, 1'b0);
      wait_done();
      repeat (2) @(negedge clk);
      check("queue_empty", q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
